mux_nway_arb: RTL

Registered N-way, WIDTH-bit multiplexer with per-channel valid/ready handshakes. It generalises the fixed 8-way 16-bit selection mux to a parameterised arbitrating mux: the block chooses among requesting input channels itself, rather than taking an external select, and registers the chosen word on a single output channel. It sits between several producers (ALU result, memory read, I/O) and one shared consumer, such as the register-file write port or a shared bus.

---
 rtl/mux_nway_arb.sv | 74 +++++++
 1 files changed

// File: rtl/mux_nway_arb.sv
// Arbitrating N-way registered mux: round-robin or fixed-priority grant into a single output register.
// Latency 1 cycle; inputs stall (in_ready=0) only while the held word is not being drained.
module mux_nway_arb #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_sel
);

  localparam int SW = $clog2(N);
  localparam logic [SW:0]   NW   = (SW+1)'(N);
  localparam logic [SW-1:0] LAST = SW'(N-1);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    base;
  logic [SW-1:0]    off;
  logic [SW-1:0]    gidx;
  logic [SW-1:0]    ptr_nxt;
  logic [2*N-2:0]   dbl;
  logic [N-1:0]     rot;
  logic [SW:0]      sum;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] gnt_dat;

  always_comb begin
    // No accepts while reset is asserted, so producers never see a lost handshake.
    load  = rst_n & (~out_valid | out_ready);
    base  = (MODE == 0) ? ptr : '0;
    // Doubled request vector: a single part-select rotates the search to start at base.
    dbl   = {in_valid[N-2:0], in_valid};
    rot   = dbl[base +: N];
    found = |in_valid;
    off   = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) off = SW'(i);
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NW) sum = sum - NW;
    gidx    = sum[SW-1:0];
    ptr_nxt = (gidx == LAST) ? '0 : gidx + SW'(1);
    gnt_dat = in_data[gidx*WIDTH +: WIDTH];
    in_ready = '0;
    if (load && found) in_ready[gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_data  <= gnt_dat;
        out_sel   <= gidx;
        out_valid <= 1'b1;
        if (MODE == 0) ptr <= ptr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
